trivium_ks_xor: RTL and testbench

TRIVIUM_KS_XOR -- requirements
Module: trivium_ks_xor

---
 rtl/trivium_pkg.sv | 13 +
 rtl/trivium_ks_fifo.sv | 55 +++++
 rtl/trivium_ks_xor.sv | 153 +++++++++++++++
 tb/tb_trivium_ks_xor.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// Shared types and widths for the Trivium keystream XOR datapath.
package trivium_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/trivium_ks_fifo.sv
// Keystream byte FIFO with first-word fall-through read; push and pop may
// coincide at any fill level, including full.
module trivium_ks_fifo
  import trivium_pkg::*;
#(
  parameter int unsigned KS_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [BYTE_W-1:0]         wdata,
  output logic [BYTE_W-1:0]         rdata,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(KS_DEPTH):0] count
);

  localparam int unsigned AW = $clog2(KS_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [BYTE_W-1:0] mem [KS_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(KS_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/trivium_ks_xor.sv
// Packs serial Trivium keystream into bytes and XORs them onto a plaintext
// byte stream. Define TRIVIUM_KS_XOR_CNT_EN to expose the byte_cnt output.
module trivium_ks_xor
  import trivium_pkg::*;
#(
  parameter int unsigned KS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              ks_bit,
  input  logic              ks_valid,
  output logic              ks_ready,
  input  logic [BYTE_W-1:0] pt_data,
  input  logic              pt_valid,
  output logic              pt_ready,
  output logic [BYTE_W-1:0] ct_data,
  output logic              ct_valid,
  input  logic              ct_ready,
  output logic              busy,
`ifdef TRIVIUM_KS_XOR_CNT_EN
  output logic [LEN_W-1:0]  byte_cnt,
`endif
  output logic              done
);

  localparam int unsigned CW = $clog2(KS_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  pack_cnt;
  logic [LEN_W-1:0]  pt_cnt;
  logic [LEN_W-1:0]  ct_cnt;
  logic [2:0]        bit_idx;
  logic [BYTE_W-2:0] pack_sr;
  logic [BYTE_W-1:0] pend_byte;
  logic              pend;
  logic [BYTE_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              run;
  logic              ks_fire;
  logic              pt_fire;
  logic              ct_fire;

  assign run     = (state == RUN);
  assign ks_fire = ks_valid && ks_ready;
  assign pt_fire = pt_valid && pt_ready;
  assign ct_fire = ct_valid && ct_ready;

  // Readiness depends only on registered state (and the sink's ready for pt)
  assign ks_ready = run && (pack_cnt < len_q) && !fifo_full &&
                    (({1'b0, fifo_count} + SW'(pend)) < SW'(KS_DEPTH));
  assign pt_ready = run && !fifo_empty && (pt_cnt < len_q) &&
                    (!ct_valid || ct_ready);

`ifdef TRIVIUM_KS_XOR_CNT_EN
  assign byte_cnt = ct_cnt;
`endif

  trivium_ks_fifo #(
    .KS_DEPTH(KS_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pend),
    .pop   (pt_fire),
    .wdata (pend_byte),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Control FSM, counters, bit packer and ciphertext register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      len_q     <= '0;
      pack_cnt  <= '0;
      pt_cnt    <= '0;
      ct_cnt    <= '0;
      bit_idx   <= '0;
      pack_sr   <= '0;
      pend_byte <= '0;
      pend      <= 1'b0;
      ct_data   <= '0;
      ct_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      pend <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            len_q    <= len;
            pack_cnt <= '0;
            pt_cnt   <= '0;
            ct_cnt   <= '0;
            bit_idx  <= '0;
            if (len != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (ct_fire && (ct_cnt == len_q - LEN_W'(1))) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // LSB-first packing: shift in at the top so the first bit lands in bit 0
      if (ks_fire) begin
        pack_sr <= {ks_bit, pack_sr[BYTE_W-2:1]};
        bit_idx <= bit_idx + 3'd1;
        if (bit_idx == 3'd7) begin
          pend      <= 1'b1;
          pend_byte <= {ks_bit, pack_sr};
          pack_cnt  <= pack_cnt + LEN_W'(1);
        end
      end

      if (pt_fire) begin
        ct_data  <= pt_data ^ fifo_rdata;
        ct_valid <= 1'b1;
        pt_cnt   <= pt_cnt + LEN_W'(1);
      end else if (ct_fire) begin
        ct_valid <= 1'b0;
      end

      if (ct_fire) ct_cnt <= ct_cnt + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_trivium_ks_xor.sv
// Directed, scoreboard-checked bench for trivium_ks_xor.
module tb_trivium_ks_xor;
  import trivium_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] len;
  logic        ks_bit, ks_valid, ks_ready;
  logic [7:0]  pt_data;
  logic        pt_valid, pt_ready;
  logic [7:0]  ct_data;
  logic        ct_valid, ct_ready;
  logic        busy, done;
`ifdef TRIVIUM_KS_XOR_CNT_EN
  logic [15:0] byte_cnt;
`endif

  always #5 clk = ~clk;

  trivium_ks_xor #(.KS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .ks_bit(ks_bit), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
    .busy(busy),
`ifdef TRIVIUM_KS_XOR_CNT_EN
    .byte_cnt(byte_cnt),
`endif
    .done(done)
  );

  int n_assert = 0;
  int n_fail   = 0;

  bit         ks_q[$];
  logic [7:0] pt_q[$];
  logic [7:0] kb_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] ct_log[$];
  int         ks_p, pt_p, ct_p;
  logic       start_req;
  logic [15:0] len_req;
  int         ks_acc, pt_acc, ct_beats, done_cnt, mbit, cnt_model;
  logic [7:0] mbyte;
  bit         busy_seen, any_seen, ctv_seen, hold_chk;
  logic [7:0] hold_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_msg();
    ks_q.delete(); pt_q.delete(); kb_q.delete(); exp_q.delete(); ct_log.delete();
    ks_acc = 0; pt_acc = 0; ct_beats = 0; done_cnt = 0; mbit = 0; mbyte = 8'h00;
    busy_seen = 0; any_seen = 0; ctv_seen = 0; hold_chk = 0;
    ks_p = 100; pt_p = 100; ct_p = 100;
  endtask

  // One clock: drive at negedge, sample #1 later, model every handshake
  task automatic cycle();
    logic [7:0] e;
    @(negedge clk);
    start = start_req; len = len_req; start_req = 1'b0;
    ks_valid = (ks_q.size() > 0) && ($urandom_range(99) < ks_p);
    ks_bit   = ks_valid ? ks_q[0] : 1'b0;
    pt_valid = (pt_q.size() > 0) && ($urandom_range(99) < pt_p);
    pt_data  = pt_valid ? pt_q[0] : 8'h00;
    ct_ready = ($urandom_range(99) < ct_p);
    #1;
    if (hold_chk) begin
      check("ct_hold_valid", 32'(ct_valid), 32'd1);
      check("ct_hold_data", 32'(ct_data), 32'(hold_data));
    end
    if (busy) busy_seen = 1;
    if (ks_ready || pt_ready || ct_valid) any_seen = 1;
    if (ct_valid) ctv_seen = 1;
    if (done) done_cnt++;
`ifdef TRIVIUM_KS_XOR_CNT_EN
    check("byte_cnt", 32'(byte_cnt), 32'(cnt_model));
    if (start && !busy) cnt_model = 0;
`endif
    if (ks_valid && ks_ready) begin
      mbyte[mbit] = ks_q.pop_front();
      ks_acc++; mbit++;
      if (mbit == 8) begin kb_q.push_back(mbyte); mbit = 0; end
    end
    if (pt_valid && pt_ready) begin
      pt_acc++;
      check("ks_byte_avail", 32'(kb_q.size() > 0), 32'd1);
      e = pt_q.pop_front();
      if (kb_q.size() > 0) e = e ^ kb_q.pop_front();
      exp_q.push_back(e);
    end
    if (ct_valid && ct_ready) begin
      check("ct_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("ct_data", 32'(ct_data), 32'(exp_q.pop_front()));
      ct_log.push_back(ct_data);
      ct_beats++;
`ifdef TRIVIUM_KS_XOR_CNT_EN
      cnt_model++;
`endif
    end
    hold_chk  = ct_valid && !ct_ready;
    hold_data = ct_data;
  endtask

  task automatic run_until_done(input int budget);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin cycle(); n++; end
    check("done_timeout", 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic test_len1();
    new_msg();
    ks_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    pt_q.push_back(8'hFF);
    len_req = 16'd1; start_req = 1'b1;
    run_until_done(100);
    repeat (3) cycle();
    check("len1_beats", 32'(ct_beats), 32'd1);
    if (ct_log.size() > 0) check("len1_ct", 32'(ct_log[0]), 32'hFE);
    check("len1_done_cnt", 32'(done_cnt), 32'd1);
    check("len1_ks_acc", 32'(ks_acc), 32'd8);
    check("len1_ks_ready_after", 32'(ks_ready), 32'd0);
    check("len1_busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] g;
    bit ks_all[$];
    logic [7:0] pt_all[$];

    reset = 1'b0; start = 1'b0; len = '0; ks_bit = 1'b0; ks_valid = 1'b0;
    pt_data = '0; pt_valid = 1'b0; ct_ready = 1'b0; start_req = 1'b0; len_req = '0;
    cnt_model = 0;
    new_msg();
    repeat (2) @(negedge clk);
    #1;
    check("rst_ks_ready", 32'(ks_ready), 32'd0);
    check("rst_pt_ready", 32'(pt_ready), 32'd0);
    check("rst_ct_valid", 32'(ct_valid), 32'd0);
    check("rst_ct_data", 32'(ct_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single byte: 0x01 keystream XOR 0xFF plaintext
    test_len1();

    // Zero-length message
    new_msg();
    len_req = 16'd0; start_req = 1'b1;
    cycle();
    check("len0_no_done_yet", 32'(done_cnt), 32'd0);
    cycle();
    check("len0_done_next", 32'(done_cnt), 32'd1);
    repeat (3) cycle();
    check("len0_single_done", 32'(done_cnt), 32'd1);
    check("len0_busy_never", 32'(busy_seen), 32'd0);
    check("len0_no_handshake", 32'(any_seen), 32'd0);

    // Backpressure: FIFO fills, ciphertext held, then drained in order
    new_msg();
    repeat (72) ks_q.push_back(1'b1);
    for (int i = 0; i < 8; i++) pt_q.push_back(8'(i));
    ct_p = 0;
    len_req = 16'd8; start_req = 1'b1;
    repeat (60) cycle();
    check("bp_ks_acc", 32'(ks_acc), 32'd40);
    check("bp_ks_ready_low", 32'(ks_ready), 32'd0);
    check("bp_pt_acc", 32'(pt_acc), 32'd1);
    check("bp_ct_valid", 32'(ct_valid), 32'd1);
    check("bp_ct_data", 32'(ct_data), 32'hFF);
    ct_p = 100;
    run_until_done(100);
    check("bp_beats", 32'(ct_beats), 32'd8);
    check("bp_ks_surplus", 32'(ks_acc), 32'd64);
    for (int i = 0; i < ct_log.size() && i < 8; i++)
      check("bp_order", 32'(ct_log[i]), 32'(8'hFF - 8'(i)));

    // Random handshakes checked against a golden XOR
    new_msg();
    for (int i = 0; i < 40; i++) ks_all.push_back(1'($urandom_range(1)));
    for (int i = 0; i < 3; i++) pt_all.push_back(8'($urandom_range(255)));
    ks_q = ks_all; pt_q = pt_all;
    ks_p = 50; pt_p = 50; ct_p = 50;
    len_req = 16'd3; start_req = 1'b1;
    run_until_done(600);
    check("rnd_beats", 32'(ct_beats), 32'd3);
    check("rnd_ks_acc", 32'(ks_acc), 32'd24);
    for (int b = 0; b < 3 && b < ct_log.size(); b++) begin
      for (int k = 0; k < 8; k++) g[k] = ks_all[8*b + k];
      check("rnd_golden", 32'(ct_log[b]), 32'(pt_all[b] ^ g));
    end

    // Reset mid-message
    new_msg();
    repeat (48) ks_q.push_back(1'($urandom_range(1)));
    repeat (5) pt_q.push_back(8'($urandom_range(255)));
    len_req = 16'd5; start_req = 1'b1;
    begin
      int n = 0;
      while (ct_beats < 2 && n < 300) begin cycle(); n++; end
      check("abort_reach_byte2", 32'(ct_beats >= 2), 32'd1);
    end
    ks_valid = 1'b0; pt_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("abort_ks_ready", 32'(ks_ready), 32'd0);
    check("abort_pt_ready", 32'(pt_ready), 32'd0);
    check("abort_ct_valid", 32'(ct_valid), 32'd0);
    check("abort_ct_data", 32'(ct_data), 32'h00);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cnt_model = 0;
    new_msg();
    repeat (10) cycle();
    check("abort_no_ct_after", 32'(ctv_seen), 32'd0);
    check("abort_idle_busy", 32'(busy), 32'd0);
    test_len1();

`ifdef TRIVIUM_KS_XOR_CNT_EN
    // Ciphertext byte counter stepping, holding and clearing
    new_msg();
    repeat (40) ks_q.push_back(1'($urandom_range(1)));
    repeat (5) pt_q.push_back(8'($urandom_range(255)));
    len_req = 16'd5; start_req = 1'b1;
    run_until_done(200);
    repeat (4) cycle();
    check("cnt_hold", 32'(byte_cnt), 32'd5);
    new_msg();
    repeat (8) ks_q.push_back(1'b0);
    pt_q.push_back(8'h5A);
    len_req = 16'd1; start_req = 1'b1;
    cycle(); cycle();
    check("cnt_clear", 32'(byte_cnt), 32'd0);
    run_until_done(100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
